// File: rtl/pm_pkg.sv
// rtl/pm_pkg.sv - shared write-size encodes and loader state enum
package pm_pkg;

  localparam logic [1:0] WS_BYTE  = 2'd0;
  localparam logic [1:0] WS_WORD  = 2'd1;
  localparam logic [1:0] WS_DWORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_COLLECT,
    ST_WRITE,
    ST_WAIT_WR,
    ST_DONE,
    ST_ERR
  } pm_state_e;

endpackage

// File: rtl/pm_loader.sv
// rtl/pm_loader.sv - length-prefixed byte stream to doubleword program-memory writes
module pm_loader
  import pm_pkg::*;
#(
  parameter int ADDR_DEPTH       = 2048,
  parameter int ADDR_WIDTH       = $clog2(ADDR_DEPTH),
  parameter int DOUBLEWORD_WIDTH = 64,
  parameter int LOAD_BASE        = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic                        wr_ins,
  output logic [ADDR_WIDTH-1:0]       addr_wr,
  output logic [DOUBLEWORD_WIDTH-1:0] data_bus_wr,
  output logic [1:0]                  data_type_wr,
  input  logic                        wr_idle,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [ADDR_WIDTH:0]         bytes_loaded
);

  localparam logic [ADDR_WIDTH-1:0] LOAD_BASE_A = ADDR_WIDTH'(LOAD_BASE);
  localparam logic [31:0]           CAPACITY    = 32'(ADDR_DEPTH - LOAD_BASE);

  pm_state_e                   state_q, state_d;
  logic [15:0]                 len_q, len_d;
  logic [ADDR_WIDTH:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]       ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [DOUBLEWORD_WIDTH-1:0] buf_q, buf_d;
  logic [DOUBLEWORD_WIDTH-1:0] data_q, data_d;
  logic                        rx_ready_q, rx_ready_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic                        accept;
  logic [ADDR_WIDTH:0]         cnt_inc;
  logic                        last_byte;
  logic [15:0]                 len_full;
  logic [DOUBLEWORD_WIDTH-1:0] packed_w;

  assign accept    = rx_valid && rx_ready_q;
  assign cnt_inc   = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign last_byte = (32'(cnt_inc) == {16'd0, len_q});
  assign len_full  = {rx_data, len_q[7:0]};

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    data_d   = data_q;
    packed_w = buf_q;
    packed_w[{cnt_q[2:0], 3'b000} +: 8] = rx_data;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN_LO;
          len_d   = '0;
          cnt_d   = '0;
          ptr_d   = LOAD_BASE_A;
          buf_d   = '0;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = ST_DONE;
          end else if ({16'd0, len_full} > CAPACITY) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          buf_d = packed_w;
          cnt_d = cnt_inc;
          // Snapshot address and data here so they hold steady until the next write.
          if (cnt_q[2:0] == 3'd7 || last_byte) begin
            state_d = ST_WRITE;
            data_d  = packed_w;
            addr_d  = ptr_q;
          end
        end
      end
      ST_WRITE: begin
        if (wr_idle) begin
          state_d = ST_WAIT_WR;
        end
      end
      ST_WAIT_WR: begin
        if (wr_idle) begin
          if (32'(cnt_q) != {16'd0, len_q}) begin
            state_d = ST_COLLECT;
            ptr_d   = ptr_q + ADDR_WIDTH'(8);
            buf_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) || (state_d == ST_COLLECT);
    busy_d     = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      ptr_q      <= LOAD_BASE_A;
      addr_q     <= LOAD_BASE_A;
      buf_q      <= '0;
      data_q     <= '0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      data_q     <= data_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // The request is held off by wr_idle so a stalled port never sees a second pulse.
  assign wr_ins       = (state_q == ST_WRITE) && wr_idle;
  assign rx_ready     = rx_ready_q;
  assign addr_wr      = addr_q;
  assign data_bus_wr  = data_q;
  assign data_type_wr = WS_DWORD;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign bytes_loaded = cnt_q;

endmodule

// File: tb/tb_pm_loader.sv
// tb/tb_pm_loader.sv - scoreboard bench for pm_loader
module tb_pm_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        wr_ins;
  logic [10:0] addr_wr;
  logic [63:0] data_bus_wr;
  logic [1:0]  data_type_wr;
  logic        wr_idle = 1'b1;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] bytes_loaded;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  int wr_expected = 0;
  logic [74:0] exp_q[$];

  always #5 clk = ~clk;

  pm_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_ins(wr_ins), .addr_wr(addr_wr), .data_bus_wr(data_bus_wr),
    .data_type_wr(data_type_wr), .wr_idle(wr_idle),
    .busy(busy), .done(done), .err(err), .bytes_loaded(bytes_loaded)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write request is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n && wr_ins) begin
      logic [74:0] e;
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got addr %h data %h expected no write", addr_wr, data_bus_wr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(addr_wr), 64'(e[74:64]));
        check("wr_data", data_bus_wr, e[63:0]);
        check("wr_type", 64'(data_type_wr), 64'd2);
      end
    end
  end

  task automatic expect_wr(input logic [10:0] a, input logic [63:0] d);
    exp_q.push_back({a, d});
    wr_expected++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!done && !err && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("end_timeout", 64'(done | err), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_type", 64'(data_type_wr), 64'd2);
    rst_n = 1'b1;
    @(negedge clk);

    // Single full doubleword.
    expect_wr(11'h000, 64'h8877665544332211);
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    send_byte(8'h08); send_byte(8'h00);
    for (int i = 1; i <= 7; i++) send_byte(8'(8'h11 * i));
    send_byte(8'h88);
    check("wr_latency", 64'(wr_ins), 64'd1);
    wait_end();
    check("t1_done", 64'(done), 64'd1);
    check("t1_bytes", 64'(bytes_loaded), 64'd8);
    check("t1_busy", 64'(busy), 64'd0);

    // 11 bytes: second write is zero-padded.
    expect_wr(11'h000, 64'h0807060504030201);
    expect_wr(11'h008, 64'h00000000000B0A09);
    pulse_start();
    check("t2_done_cleared", 64'(done), 64'd0);
    send_byte(8'h0B); send_byte(8'h00);
    for (int i = 1; i <= 11; i++) send_byte(8'(i));
    wait_end();
    check("t2_done", 64'(done), 64'd1);
    check("t2_bytes", 64'(bytes_loaded), 64'd11);

    // Write port stall after the first write.
    expect_wr(11'h000, 64'h1716151413121110);
    expect_wr(11'h008, 64'h1F1E1D1C1B1A1918);
    pulse_start();
    send_byte(8'h10); send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
    @(posedge clk);
    #1 wr_idle = 1'b0;
    rx_data = 8'h18;
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rx_ready", 64'(rx_ready), 64'd0);
    end
    check("stall_wr_count", 64'(wr_seen), 64'd4);
    check("stall_bytes", 64'(bytes_loaded), 64'd8);
    wr_idle = 1'b1;
    for (int i = 8; i < 16; i++) send_byte(8'(8'h10 + i));
    wait_end();
    check("t3_done", 64'(done), 64'd1);
    check("t3_bytes", 64'(bytes_loaded), 64'd16);

    // Zero length, with a start pulse while busy.
    pulse_start();
    send_byte(8'h00);
    pulse_start();
    send_byte(8'h00);
    check("t4_done", 64'(done), 64'd1);
    check("t4_bytes", 64'(bytes_loaded), 64'd0);
    rx_data = 8'h5A;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("done_rx_ready", 64'(rx_ready), 64'd0);
    rx_valid = 1'b0;

    // Length one past capacity.
    pulse_start();
    send_byte(8'h01); send_byte(8'h08);
    check("t5_err", 64'(err), 64'd1);
    check("t5_done", 64'(done), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_rx_ready", 64'(rx_ready), 64'd0);

    // Length exactly at capacity is accepted; reset mid-collect.
    pulse_start();
    check("t6_err_cleared", 64'(err), 64'd0);
    send_byte(8'h00); send_byte(8'h08);
    check("cap_rx_ready", 64'(rx_ready), 64'd1);
    check("cap_err", 64'(err), 64'd0);
    send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2);
    check("t6_bytes", 64'(bytes_loaded), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rx_ready", 64'(rx_ready), 64'd0);
    check("arst_bytes", 64'(bytes_loaded), 64'd0);
    check("arst_addr", 64'(addr_wr), 64'd0);
    check("arst_data", data_bus_wr, 64'd0);
    check("arst_type", 64'(data_type_wr), 64'd2);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load after reset.
    expect_wr(11'h000, 64'h0000000000CCBBAA);
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    wait_end();
    check("t7_done", 64'(done), 64'd1);
    check("t7_bytes", 64'(bytes_loaded), 64'd3);

    repeat (3) @(negedge clk);
    check("wr_total", 64'(wr_seen), 64'(wr_expected));
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pm_loader.md
PM_LOADER -- requirements
Module: pm_loader

Interface
REQ-001 SHALL have parameter ADDR_DEPTH, default 2048, meaning the program-memory size in bytes.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(ADDR_DEPTH), meaning the memory address width.
REQ-003 SHALL have parameter DOUBLEWORD_WIDTH, default 64, meaning the memory write-bus width.
REQ-004 SHALL have parameter LOAD_BASE, default 0, meaning the first memory byte address written; it is 8-aligned.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that begins a load.
REQ-008 SHALL have port rx_data, input, 8 bits: incoming byte stream (from the UART RX FIFO).
REQ-009 SHALL have port rx_valid, input, 1 bit: rx_data holds a valid byte.
REQ-010 SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-011 SHALL have port wr_ins, output, 1 bit: memory write request pulse.
REQ-012 SHALL have port addr_wr, output, ADDR_WIDTH bits: memory write byte address.
REQ-013 SHALL have port data_bus_wr, output, DOUBLEWORD_WIDTH bits: memory write data, little-endian.
REQ-014 SHALL have port data_type_wr, output, 2 bits: memory write size; the loader always drives DWORD (2).
REQ-015 SHALL have port wr_idle, input, 1 bit: the memory write port is idle.
REQ-016 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-017 SHALL have port done, output, 1 bit: the last load completed successfully (level signal).
REQ-018 SHALL have port err, output, 1 bit: the last load was rejected because its length exceeded capacity (level signal).
REQ-019 SHALL have port bytes_loaded, output, ADDR_WIDTH+1 bits: count of payload bytes accepted so far.

Function
REQ-020 SHALL transfer bytes only when rx_valid and rx_ready are both 1 on the same clock edge.
REQ-021 SHALL implement the states IDLE, LEN_LO, LEN_HI, COLLECT, WRITE, WAIT_WR, DONE and ERR.
REQ-022 SHALL move from IDLE, DONE or ERR to LEN_LO on start; while busy, start is ignored.
REQ-023 SHALL, on start, clear done, err and bytes_loaded, and set the write pointer to LOAD_BASE.
REQ-024 SHALL take the first accepted byte as length[7:0] and the second as length[15:8], then leave LEN_HI as follows:
- length=0 -> DONE;
- length > ADDR_DEPTH-LOAD_BASE -> ERR;
- otherwise -> COLLECT.
REQ-025 SHALL, in COLLECT, place each accepted byte at lane (bytes_loaded mod 8), with lane 0 at bits [7:0], and increment bytes_loaded.
REQ-026 SHALL go to WRITE when lane 7 is filled or when the last payload byte is accepted; unfilled lanes are 0x00.
REQ-027 SHALL assert wr_ins for exactly one cycle in WRITE, and only while wr_idle=1; addr_wr, data_bus_wr and data_type_wr SHALL be stable from that cycle until the next WRITE.
REQ-028 SHALL go from WRITE to WAIT_WR, and leave WAIT_WR only when wr_idle=1, to:
- COLLECT, with the pointer advanced by 8 and the pack buffer cleared, if payload bytes remain;
- DONE otherwise.
REQ-029 SHALL drive rx_ready=1 only in LEN_LO, LEN_HI and COLLECT; in COLLECT it is 1 only when the pack buffer is not full.
REQ-030 SHALL keep busy=1 in every state except IDLE, DONE and ERR.
REQ-031 SHALL keep done=1 in DONE and err=1 in ERR until the next start.
REQ-032 SHALL give a latency of 1 cycle from the 8th byte accepted to the wr_ins pulse when wr_idle=1.
REQ-033 SHALL ignore rx bytes in IDLE, DONE and ERR; they are not consumed.

Reset
REQ-034 SHALL, on rst_n=0, asynchronously set: state IDLE; wr_ins=0; rx_ready=0; busy=0; done=0; err=0; bytes_loaded=0; addr_wr=LOAD_BASE; data_bus_wr=0; data_type_wr=2.
REQ-035 SHALL abandon a load interrupted by reset; already-written memory contents are not restored.

Structure
REQ-036 SHALL take the write-size encodes (BYTE=0, WORD=1, DWORD=2) and the loader state enum from the shared package pm_pkg.
REQ-037 SHALL be a single module with no sub-modules; the byte-to-doubleword pack buffer is internal.

Verification
REQ-038 SHALL be verified with start, then bytes 08 00 11 22 33 44 55 66 77 88 -> one wr_ins with addr_wr=0x000 and data=0x8877665544332211, then done=1 and bytes_loaded=8.
REQ-039 SHALL be verified with length 0x000B followed by 11 payload bytes -> two writes, at 0x000 and 0x008, the second with lanes 3..7 equal to 0x00.
REQ-040 SHALL be verified with length 0x0801 and ADDR_DEPTH=2048 -> err=1, no wr_ins, and rx_ready=0 afterwards.
REQ-041 SHALL be verified with wr_idle held at 0 for 5 cycles after wr_ins -> no further wr_ins, rx_ready=0 while the buffer is full, and correct resumption afterwards.
REQ-042 SHALL be verified with rst_n pulsed low mid-COLLECT, after 3 payload bytes -> all outputs take their reset values immediately, and a subsequent load succeeds.
REQ-043 SHALL be verified with length 0 -> done=1 two accepted bytes after start and no wr_ins; a start pulse while busy has no effect.
